id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection, sitting directly upstream of the ALU.
- Captures decoded instruction fields from ID and resolves RAW hazards by forwarding from MEM and WB.
- Drives the ALU's a, b and alu_ctrl inputs, plus store data and downstream control.
- Detects load-use hazards and inserts a bubble.

Parameters:
- DW, 32, datapath width.
- RW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  downstream hold; EX contents retained.
- flush  in  1  kill EX contents (branch/jump redirect).
- id_valid  in  1  ID holds a real instruction.
- id_rs_data, id_rt_data  in  DW  register file read data.
- id_imm  in  DW  immediate, already sign- or zero-extended by ID.
- id_shamt  in  5  shift amount field.
- id_rs_addr, id_rt_addr, id_rd_addr  in  RW  source and destination addresses.
- id_alu_ctrl  in  4  ALU op code (AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLL 1000, LUI 1001, SRL 1010, SRA 1011).
- id_alu_src  in  1  b = imm instead of rt.
- id_shift_imm  in  1  a = zero-extended shamt instead of rs.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits.
- mem_reg_write  in  1  MEM-stage write enable.
- mem_rd_addr  in  RW  MEM-stage destination.
- mem_fwd_data  in  DW  MEM-stage result.
- wb_reg_write  in  1  WB-stage write enable.
- wb_rd_addr  in  RW  WB-stage destination.
- wb_data  in  DW  WB-stage result.
- alu_a, alu_b  out  DW  ALU operands (combinational from register and forward muxes).
- alu_ctrl  out  4  registered op code.
- ex_store_data  out  DW  forwarded rt value.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control.
- ex_rd_addr  out  RW  registered destination.
- load_use_stall  out  1  combinational; the ID/IF stages must hold when set.
- bubble_cnt  out  16  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0):
  - All registered fields 0, so ex_valid=0 and alu_ctrl=0000.
  - alu_a=alu_b=0 and load_use_stall=0 while in reset.
- Per-edge update priority:
  1. flush → bubble (ex_valid and all control bits 0, alu_ctrl 0000, data fields 0).
  2. stall → hold.
  3. load_use_stall → bubble.
  4. Otherwise capture ID fields; ex_valid = id_valid.
  5. If id_valid=0, the control bits are also captured as 0.
- Hold refresh: while held, stored rs/rt data are overwritten with their current forwarded values, so a WB result retiring during the stall is not lost.
- Forwarding (per operand, rs and rt independently):
  - Source address 0 is never forwarded.
  - MEM match (mem_reg_write & mem_rd_addr==addr) wins over WB match.
  - Otherwise the stored register value is used.
- Operand select:
  - alu_a = id_shift_imm ? {27'b0, shamt} : fwd_rs.
  - alu_b = alu_src ? imm : fwd_rt.
  - ex_store_data = fwd_rt always.
- Load-use detection:
  - load_use_stall = ex_valid & ex_mem_read & ex_rd_addr≠0 & id_valid & (ex_rd_addr==id_rs_addr | ex_rd_addr==id_rt_addr).
  - rt is compared even when alu_src=1 (conservative).
- Latency: ID fields appear on the outputs one cycle after capture; forwarding adds no cycles.
- Simultaneous flush and load_use_stall: flush wins, then load_use_stall deasserts because ex_valid=0.
- Reset mid-stall: everything cleared; no held data survives.

Optional Feature:
- Macro: IDEX_BUBBLE_CNT_EN.
- Defined: bubble_cnt increments on every edge where a bubble is inserted (flush or load-use) and saturates at 0xFFFF. It resets to 0 asynchronously.
- Undefined: bubble_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Reset then capture: id_valid=1, rs_data=5, rt_data=7, alu_ctrl=0010 → next cycle alu_a=5, alu_b=7, alu_ctrl=0010, ex_valid=1.
- MEM-over-WB priority: EX rs_addr=3 with mem_rd_addr=3 (data 0x11) and wb_rd_addr=3 (data 0x22) both writing → alu_a=0x11. Same case with rs_addr=0 → alu_a equals the stored rs value.
- Shift immediate: id_shift_imm=1, shamt=4, rt_data=0x1, alu_ctrl=1000 → alu_a=4, alu_b=1. Also lui with alu_src=1, imm=0x1234 → alu_b=0x1234.
- Load-use: EX is a load with rd=8; ID uses rs=8 → load_use_stall=1, next cycle ex_valid=0, bubble_cnt +1 (when enabled).
- Stall refresh: hold 3 cycles while WB writes r9=0xABCD (stored rt for r9 is stale) → after stall and WB gone, alu_b=0xABCD.
- Flush during stall+load-use: flush=stall=1 with the hazard present → next cycle ex_valid=0 and all control bits 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, ALU operand muxing and load-use bubble insertion.
// Optional bubble counter enabled by defining IDEX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic [3:0]    id_alu_ctrl,
  input  logic          id_alu_src,
  input  logic          id_shift_imm,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic          wb_reg_write,
  input  logic [RW-1:0] wb_rd_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic [RW-1:0] ex_rd_addr,
  output logic          load_use_stall,
  output logic [15:0]   bubble_cnt
);

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          alu_src;
    logic          shift_imm;
    logic [3:0]    alu_ctrl;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [4:0]    shamt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
  } ex_t;

  ex_t ex, id_pkt;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // An empty ID slot still moves through, but must never write or touch memory.
  always_comb begin
    id_pkt            = '0;
    id_pkt.valid      = id_valid;
    id_pkt.reg_write  = id_valid & id_reg_write;
    id_pkt.mem_read   = id_valid & id_mem_read;
    id_pkt.mem_write  = id_valid & id_mem_write;
    id_pkt.mem_to_reg = id_valid & id_mem_to_reg;
    id_pkt.alu_src    = id_alu_src;
    id_pkt.shift_imm  = id_shift_imm;
    id_pkt.alu_ctrl   = id_alu_ctrl;
    id_pkt.rd         = id_rd_addr;
    id_pkt.rs         = id_rs_addr;
    id_pkt.rt         = id_rt_addr;
    id_pkt.shamt      = id_shamt;
    id_pkt.rs_data    = id_rs_data;
    id_pkt.rt_data    = id_rt_data;
    id_pkt.imm        = id_imm;
  end

  always_comb begin
    fwd_rs = ex.rs_data;
    if (ex.rs != '0) begin
      if (mem_reg_write && mem_rd_addr == ex.rs)     fwd_rs = mem_fwd_data;
      else if (wb_reg_write && wb_rd_addr == ex.rs)  fwd_rs = wb_data;
    end
    fwd_rt = ex.rt_data;
    if (ex.rt != '0) begin
      if (mem_reg_write && mem_rd_addr == ex.rt)     fwd_rt = mem_fwd_data;
      else if (wb_reg_write && wb_rd_addr == ex.rt)  fwd_rt = wb_data;
    end
  end

  assign alu_a         = ex.shift_imm ? {{(DW-5){1'b0}}, ex.shamt} : fwd_rs;
  assign alu_b         = ex.alu_src ? ex.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_ctrl      = ex.alu_ctrl;
  assign ex_valid      = ex.valid;
  assign ex_reg_write  = ex.reg_write;
  assign ex_mem_read   = ex.mem_read;
  assign ex_mem_write  = ex.mem_write;
  assign ex_mem_to_reg = ex.mem_to_reg;
  assign ex_rd_addr    = ex.rd;

  // rt is compared even for immediate-operand ops; a rare false stall is cheaper than decoding use.
  assign load_use_stall = ex.valid & ex.mem_read & (ex.rd != '0) & id_valid &
                          ((ex.rd == id_rs_addr) | (ex.rd == id_rt_addr));

  // During a hold the stored operands absorb any MEM/WB result so it survives the stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ex <= '0;
    else if (flush)           ex <= '0;
    else if (stall) begin
      ex.rs_data <= fwd_rs;
      ex.rt_data <= fwd_rt;
    end
    else if (load_use_stall)  ex <= '0;
    else                      ex <= id_pkt;
  end

`ifdef IDEX_BUBBLE_CNT_EN
  logic        bubble;
  logic [15:0] cnt;
  assign bubble = flush | (~stall & load_use_stall);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (bubble && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign bubble_cnt = cnt;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a behavioural EX-slot model.
module tb_id_ex_stage;
  logic        clk = 0, rst_n = 0, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm, mem_fwd_data, wb_data;
  logic [4:0]  id_shamt, id_rs_addr, id_rt_addr, id_rd_addr, mem_rd_addr, wb_rd_addr;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_shift_imm, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;
  logic [4:0]  ex_rd_addr;
  logic [15:0] bubble_cnt;

  int total = 0, bad = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_shift_imm(id_shift_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
    .mem_fwd_data(mem_fwd_data), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_rd_addr(ex_rd_addr), .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Model of the instruction sitting in EX
  typedef struct {
    bit v, rw, mr, mw, m2r, asrc, simm;
    int unsigned op, rd, rs, rt, sh, rsd, rtd, imm;
  } slot_t;
  slot_t m;
  int unsigned mcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned src(int unsigned a, int unsigned stored);
    if (a == 0) return stored;
    if (mem_reg_write && mem_rd_addr == a) return mem_fwd_data;
    if (wb_reg_write && wb_rd_addr == a) return wb_data;
    return stored;
  endfunction

  function automatic bit m_lus();
    return m.v && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs_addr || m.rd == id_rt_addr);
  endfunction

  task automatic m_clear();
    m = '{default: 0};
  endtask

  task automatic m_bubble();
    m_clear();
`ifdef IDEX_BUBBLE_CNT_EN
    if (mcnt < 65535) mcnt++;
`endif
  endtask

  task automatic m_edge();
    if (!rst_n) begin m_clear(); mcnt = 0; end
    else if (flush) m_bubble();
    else if (stall) begin
      m.rsd = src(m.rs, m.rsd);
      m.rtd = src(m.rt, m.rtd);
    end
    else if (m_lus()) m_bubble();
    else begin
      m.v = id_valid; m.rw = id_valid & id_reg_write; m.mr = id_valid & id_mem_read;
      m.mw = id_valid & id_mem_write; m.m2r = id_valid & id_mem_to_reg;
      m.asrc = id_alu_src; m.simm = id_shift_imm; m.op = id_alu_ctrl; m.rd = id_rd_addr;
      m.rs = id_rs_addr; m.rt = id_rt_addr; m.sh = id_shamt; m.rsd = id_rs_data;
      m.rtd = id_rt_data; m.imm = id_imm;
    end
  endtask

  task automatic chk_all();
    int unsigned fr, ft;
    fr = src(m.rs, m.rsd);
    ft = src(m.rt, m.rtd);
    chk("alu_a", alu_a, m.simm ? m.sh : fr);
    chk("alu_b", alu_b, m.asrc ? m.imm : ft);
    chk("store", ex_store_data, ft);
    chk("alu_ctrl", {28'd0, alu_ctrl}, m.op);
    chk("ctrl", {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
        {m.v, m.rw, m.mr, m.mw, m.m2r});
    chk("rd", {27'd0, ex_rd_addr}, m.rd);
    chk("lus", {31'd0, load_use_stall}, {31'd0, m_lus()});
    chk("bcnt", {16'd0, bubble_cnt}, mcnt);
  endtask

  // Inputs are set just after a rising edge; checks at mid-cycle, then the model steps with the edge.
  task automatic step();
    #4;
    chk_all();
    m_edge();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    {stall, flush, id_valid, id_alu_src, id_shift_imm, id_reg_write, id_mem_read} = '0;
    {id_mem_write, id_mem_to_reg, mem_reg_write, wb_reg_write} = '0;
    {id_rs_data, id_rt_data, id_imm, mem_fwd_data, wb_data} = '0;
    {id_shamt, id_rs_addr, id_rt_addr, id_rd_addr, mem_rd_addr, wb_rd_addr} = '0;
    id_alu_ctrl = '0;
  endtask

  task automatic instr(input int unsigned rs, rt, rd, rsd, rtd, input logic [3:0] op);
    id_valid = 1; id_rs_addr = rs[4:0]; id_rt_addr = rt[4:0]; id_rd_addr = rd[4:0];
    id_rs_data = rsd; id_rt_data = rtd; id_alu_ctrl = op; id_reg_write = 1;
  endtask

  initial begin
    idle(); m_clear(); mcnt = 0;
    #2;
    chk("rst_a", alu_a, 0);
    chk("rst_lus", {31'd0, load_use_stall}, 0);
    chk("rst_valid", {31'd0, ex_valid}, 0);
    @(posedge clk); #1; rst_n = 1;
    step();

    instr(1, 2, 3, 5, 7, 4'b0010); step();
    idle(); #1;
    chk("cap_a", alu_a, 5); chk("cap_b", alu_b, 7);
    chk("cap_op", {28'd0, alu_ctrl}, 4'b0010); chk("cap_v", {31'd0, ex_valid}, 1);
    step();

    instr(3, 0, 4, 32'h99, 0, 4'b0010); step();
    idle(); mem_reg_write = 1; mem_rd_addr = 3; mem_fwd_data = 32'h11;
    wb_reg_write = 1; wb_rd_addr = 3; wb_data = 32'h22; #1;
    chk("mem_over_wb", alu_a, 32'h11);
    instr(0, 0, 4, 32'h55, 0, 4'b0010); mem_rd_addr = 0; wb_rd_addr = 0; step();
    #1; chk("r0_nofwd", alu_a, 32'h55);
    idle(); step();

    instr(0, 0, 5, 0, 1, 4'b1000); id_shift_imm = 1; id_shamt = 4; step();
    idle(); #1; chk("sll_a", alu_a, 4); chk("sll_b", alu_b, 1);
    instr(0, 0, 6, 0, 0, 4'b1001); id_alu_src = 1; id_imm = 32'h1234; step();
    idle(); #1; chk("lui_b", alu_b, 32'h1234);
    step();

    instr(1, 0, 8, 0, 0, 4'b0010); id_mem_read = 1; id_mem_to_reg = 1; step();
    idle(); instr(8, 2, 9, 0, 0, 4'b0010); #1;
    chk("lu_stall", {31'd0, load_use_stall}, 1);
    step();
    #1; chk("lu_bubble", {31'd0, ex_valid}, 0);
    idle(); step();

    instr(0, 9, 10, 0, 1, 4'b0010); step();
    idle(); stall = 1; wb_reg_write = 1; wb_rd_addr = 9; wb_data = 32'hABCD;
    repeat (3) step();
    wb_reg_write = 0; wb_data = 0; #1;
    chk("refresh_b", alu_b, 32'hABCD);
    idle(); step();

    instr(1, 0, 8, 0, 0, 4'b0010); id_mem_read = 1; step();
    idle(); instr(8, 0, 9, 0, 0, 4'b0010); stall = 1; flush = 1; step();
    #1; chk("flush_ctrl", {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
    chk("flush_lus", {31'd0, load_use_stall}, 0);

    idle(); instr(2, 3, 4, 32'h77, 32'h88, 4'b0110); step();
    stall = 1; step();
    rst_n = 0; m_clear(); mcnt = 0; #1;
    chk("rst_mid_v", {31'd0, ex_valid}, 0); chk("rst_mid_a", alu_a, 0); chk("rst_mid_b", alu_b, 0);
    @(posedge clk); #1; rst_n = 1; idle(); step();

    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 9) == 0); flush = ($urandom_range(0, 14) == 0);
      id_valid = ($urandom_range(0, 4) != 0);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom); id_alu_ctrl = 4'($urandom);
      id_rs_addr = 5'($urandom_range(0, 7)); id_rt_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom_range(0, 7));
      {id_alu_src, id_shift_imm, id_reg_write, id_mem_write, id_mem_to_reg} = 5'($urandom);
      id_mem_read = ($urandom_range(0, 2) == 0);
      mem_reg_write = 1'($urandom); mem_rd_addr = 5'($urandom_range(0, 7)); mem_fwd_data = $urandom;
      wb_reg_write = 1'($urandom); wb_rd_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
